// File: rtl/row_sequencer.sv
// Row sequencer: walks every pixel row per frame through reset, integrate,
// settle and readout phases, handshaking each readout with the column ADC.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; all outputs low
// SETUP     | new row index on select, enable low (decoder select latency)
// ROW_RST   | row enabled with pixel reset driven for RST_CYCLES
// INTEGRATE | row released for the latched exposure cycle count
// SETTLE    | row enabled for SETTLE_CYCLES before readout
// READ      | readout requested until the column ADC acknowledges
// DONE      | one-cycle frame_done pulse, then back to IDLE
module row_sequencer #(
  parameter int ROWS          = 8,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int EXP_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [EXP_W-1:0]         exposure,
  input  logic                     read_ack,
  output logic [$clog2(ROWS)-1:0]  row_select,
  output logic                     row_enable,
  output logic                     row_rst,
  output logic                     read_req,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  // Phase counter must hold the full exposure range as well as both fixed dwells.
  localparam int CNT_W = (EXP_W >= RST_W && EXP_W >= SET_W) ? EXP_W :
                         ((RST_W >= SET_W) ? RST_W : SET_W);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ROW_RST   = 3'd2,
    INTEGRATE = 3'd3,
    SETTLE    = 3'd4,
    READ      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [ROW_W-1:0]   row_select_q, row_select_d;
  logic               row_enable_q, row_enable_d;
  logic               row_rst_q, row_rst_d;
  logic               read_req_q, read_req_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  // State, phase counter, row index and latched exposure registers; outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      row_select_q <= '0;
      row_enable_q <= 1'b0;
      row_rst_q    <= 1'b0;
      read_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      row_select_q <= row_select_d;
      row_enable_q <= row_enable_d;
      row_rst_q    <= row_rst_d;
      read_req_q   <= read_req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic; dwell counters count down and leave the phase on zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    row_select_d = row_select_q;
    if (abort) begin
      state_d      = IDLE;
      cnt_d        = '0;
      row_select_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_d        = exposure;
            row_select_d = '0;
            state_d      = SETUP;
          end
        end
        SETUP: begin
          cnt_d   = RST_LOAD;
          state_d = ROW_RST;
        end
        ROW_RST: begin
          if (cnt_q == '0) begin
            if (exp_q == '0) begin
              cnt_d   = SET_LOAD;
              state_d = SETTLE;
            end else begin
              cnt_d   = CNT_W'(exp_q) - CNT_W'(1);
              state_d = INTEGRATE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        INTEGRATE: begin
          if (cnt_q == '0) begin
            cnt_d   = SET_LOAD;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = READ;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        READ: begin
          if (read_ack) begin
            if (row_select_q == LAST_ROW) begin
              state_d = DONE;
            end else begin
              row_select_d = row_select_q + ROW_W'(1);
              state_d      = SETUP;
            end
          end
        end
        DONE: begin
          row_select_d = '0;
          state_d      = IDLE;
        end
        default: begin
          cnt_d        = '0;
          row_select_d = '0;
          state_d      = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop aligned with its state.
  always_comb begin
    row_enable_d = (state_d == ROW_RST) || (state_d == SETTLE) || (state_d == READ);
    row_rst_d    = (state_d == ROW_RST);
    read_req_d   = (state_d == READ);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  assign row_select = row_select_q;
  assign row_enable = row_enable_q;
  assign row_rst    = row_rst_q;
  assign read_req   = read_req_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_row_sequencer.sv
// Scoreboard bench for row_sequencer: the stimulus side predicts readout
// request edges and frame_done timing from the phase lengths; a monitor
// pops and compares whenever the DUT shows one of those events.
module tb_row_sequencer;

  localparam int ROWS = 4;
  localparam int RST  = 2;
  localparam int SET  = 2;
  localparam int K_ON   = 1;
  localparam int K_OFF  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int row;
    int cyc;
    int en_run;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] exposure;
  logic        read_ack;
  logic [1:0]  row_select;
  logic        row_enable;
  logic        row_rst;
  logic        read_req;
  logic        busy;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  ev_t ev_q[$];
  int  ack_q[$];
  int  dly_arr[ROWS];

  row_sequencer #(
    .ROWS(ROWS), .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .EXP_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .exposure(exposure), .read_ack(read_ack), .row_select(row_select),
    .row_enable(row_enable), .row_rst(row_rst), .read_req(read_req),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(input string what, output ev_t e, output bit ok);
    if (ev_q.size() == 0) begin
      n_chk++;
      n_err++;
      ok = 1'b0;
      e  = '{0, 0, 0, 0};
      $display("FAIL unexpected_%s: got event expected none (cycle %0d)", what, cyc);
    end else begin
      e  = ev_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_row_enable"}, int'(row_enable), 0);
    chk({tag, "_row_rst"}, int'(row_rst), 0);
    chk({tag, "_read_req"}, int'(read_req), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_row_select"}, int'(row_select), 0);
  endtask

  // Column ADC stand-in: acknowledges each row after its scheduled delay, noise otherwise.
  initial begin : ack_driver
    bit ack_active;
    int ack_wait;
    int ack_need;
    ack_active = 1'b0;
    ack_wait   = 0;
    ack_need   = 0;
    read_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && read_req) begin
        if (!ack_active) begin
          ack_active = 1'b1;
          ack_wait   = 0;
          ack_need   = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
        end
        read_ack = (ack_wait >= ack_need);
        ack_wait++;
      end else begin
        ack_active = 1'b0;
        read_ack   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard and checks invariants.
  initial begin : monitor
    bit         req_p;
    bit         fd_p;
    logic [1:0] sel_p;
    int         en_run;
    ev_t        e;
    bit         ok;
    req_p  = 1'b0;
    fd_p   = 1'b0;
    sel_p  = '0;
    en_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        req_p  = 1'b0;
        fd_p   = 1'b0;
        sel_p  = row_select;
        en_run = 0;
      end else begin
        if (row_select != sel_p) chk("enable_at_select_change", int'(row_enable), 0);
        if (row_rst) chk("rst_req_exclusive", int'(read_req), 0);
        if (fd_p) begin
          chk("busy_after_done", int'(busy), 0);
          chk("select_after_done", int'(row_select), 0);
        end
        if (read_req && !req_p) begin
          pop_ev("req_on", e, ok);
          if (ok) begin
            chk("req_on_kind", e.kind, K_ON);
            chk("req_on_row", int'(row_select), e.row);
            chk("req_on_cycle", cyc, e.cyc);
            chk("enable_run_before_read", en_run, e.en_run);
            chk("req_on_enable", int'(row_enable), 1);
          end
        end
        if (!read_req && req_p) begin
          pop_ev("req_off", e, ok);
          if (ok) begin
            chk("req_off_kind", e.kind, K_OFF);
            chk("req_off_cycle", cyc, e.cyc);
          end
        end
        if (frame_done) begin
          pop_ev("frame_done", e, ok);
          if (ok) begin
            chk("done_kind", e.kind, K_DONE);
            chk("done_cycle", cyc, e.cyc);
            chk("done_enable", int'(row_enable), 0);
            chk("done_busy", int'(busy), 1);
            chk("done_select", int'(row_select), ROWS - 1);
          end
        end
        en_run = row_enable ? en_run + 1 : 0;
        req_p  = read_req;
        fd_p   = frame_done;
        sel_p  = row_select;
      end
    end
  end

  // One frame: predict events from phase lengths, optionally cut short by abort (1) or reset (2).
  task automatic run_frame(input int exp, input bit noise, input int cut_row, input int cut_kind);
    int s, t, rs, l, on_c, stop;
    stop = -1;
    @(negedge clk);
    start    = 1'b1;
    exposure = 16'(exp);
    s        = cyc + 1;
    t        = s;
    for (int i = 0; i < ROWS; i++) begin
      rs   = t;
      on_c = rs + 1 + RST + exp + SET;
      l    = 1 + RST + exp + SET + dly_arr[i] + 1;
      if (cut_kind == 1 && i == cut_row) begin
        stop = rs + 1 + RST;
        break;
      end
      ev_q.push_back('{K_ON, i, on_c, (exp == 0) ? RST + SET : SET});
      ack_q.push_back(dly_arr[i]);
      if (cut_kind == 2 && i == cut_row) begin
        stop = on_c + 1;
        break;
      end
      ev_q.push_back('{K_OFF, i, rs + l, 0});
      t = t + l;
    end
    if (stop < 0) begin
      ev_q.push_back('{K_DONE, ROWS - 1, t, 0});
      stop = t;
    end
    forever begin
      @(negedge clk);
      if (cyc >= stop) begin
        start = 1'b0;
        break;
      end
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (noise) exposure = 16'($urandom);
    end
    if (cut_kind == 1) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle_outputs("after_abort");
      ev_q.delete();
      ack_q.delete();
    end else if (cut_kind == 2) begin
      #2 reset_n = 1'b0;
      #1 chk_idle_outputs("async_reset");
      ev_q.delete();
      ack_q.delete();
      @(negedge clk);
      #1 reset_n = 1'b1;
    end else begin
      repeat (2) @(negedge clk);
      chk("frame_events_drained", ev_q.size(), 0);
    end
  endtask

  task automatic set_dly(input int mode);
    for (int i = 0; i < ROWS; i++)
      dly_arr[i] = (mode < 0) ? $urandom_range(0, 5) : mode;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    reset_n  = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    exposure = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    set_dly(0);
    run_frame(3, 1'b0, -1, 0);
    set_dly(4);
    run_frame(3, 1'b0, -1, 0);
    set_dly(-1);
    run_frame(0, 1'b0, -1, 0);

    set_dly(-1);
    run_frame(3, 1'b0, 2, 1);
    set_dly(-1);
    run_frame(2, 1'b0, -1, 0);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle_outputs("start_with_abort");
    @(negedge clk);
    chk("start_with_abort_idle", int'(busy), 0);

    set_dly(-1);
    run_frame(4, 1'b1, -1, 0);

    set_dly(4);
    run_frame(2, 1'b0, 1, 2);
    set_dly(-1);
    run_frame(1, 1'b0, -1, 0);

    repeat (3) begin
      set_dly(-1);
      run_frame($urandom_range(0, 6), 1'($urandom_range(0, 1)), -1, 0);
    end

    repeat (3) @(negedge clk);
    chk("final_events_drained", ev_q.size(), 0);
    chk("final_idle", int'(busy), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/row_sequencer.md
# row_sequencer

Frame-level scan controller for the pixel array row decoder. On a start pulse it walks every row in order, drives the decoder's `select` and `enable` inputs through a per-row reset / integrate / settle / readout sequence, and handshakes each row readout with the column ADC block. It sits between the top-level sensor control (start/abort, exposure setting) and the row decoder plus column readout chain.

## Interface
- `ROWS`, 8: number of pixel rows; must match the decoder `width`; ≥2.
- `RST_CYCLES`, 4: cycles the row reset line is held per row; ≥1.
- `SETTLE_CYCLES`, 2: cycles a row is selected before readout is requested; ≥1.
- `EXP_W`, 16: width of the exposure setting.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame start request, sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE next edge from any state.
- `exposure`  in  EXP_W  integrate cycles per row; latched on accepted start.
- `read_ack`  in  1  column readout done for current row.
- `row_select`  out  $clog2(ROWS)  row index to decoder `select`.
- `row_enable`  out  1  to decoder `enable`.
- `row_rst`  out  1  pixel reset drive for selected row.
- `read_req`  out  1  readout request to column ADC.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse after last row read.

## Operation
- Clock `clk`; reset `reset_n` is asynchronous and active-low. All outputs registered.
- Reset: state IDLE; `row_select`=0, `row_enable`=0, `row_rst`=0, `read_req`=0, `busy`=0, `frame_done`=0, counters 0, latched exposure 0.
- States: IDLE, SETUP, ROW_RST, INTEGRATE, SETTLE, READ, DONE.
- IDLE: `start`=1 (and `abort`=0) → latch `exposure`, `row_select`←0, go SETUP.
- SETUP (1 cycle): `row_select` holds new row, `row_enable`=0. Covers the decoder's one-cycle registered select. → ROW_RST.
- ROW_RST (RST_CYCLES cycles): `row_enable`=1, `row_rst`=1. → INTEGRATE, or SETTLE if latched exposure = 0.
- INTEGRATE (exposure cycles): `row_enable`=0, `row_rst`=0. → SETTLE.
- SETTLE (SETTLE_CYCLES cycles): `row_enable`=1. → READ.
- READ: `row_enable`=1, `read_req`=1 until an edge samples `read_ack`=1 with `read_req`=1; then if `row_select`=ROWS-1 → DONE, else `row_select`+1, → SETUP.
- DONE (1 cycle): `frame_done`=1, `row_enable`=0, `busy`=1. → IDLE, `row_select`←0.
- `read_ack` outside READ is ignored. `start` outside IDLE is ignored (no queuing).
- `abort`=1 in any state: next edge IDLE, all outputs at reset values, no `frame_done`. `abort` beats `start` in the same cycle.
- Phase counter width ≥ max(EXP_W, $clog2(RST_CYCLES+1), $clog2(SETTLE_CYCLES+1)). Exposure up to 2^EXP_W−1 with no wrap. `row_select` never exceeds ROWS-1.

## Timing
- Start accepted at edge N: `busy`=1 and SETUP from N+1.
- Per-row length: 1 + RST_CYCLES + exposure + SETTLE_CYCLES + R cycles. R ≥ 1 is the READ dwell; R=1 when `read_ack` is already high on READ's first cycle.
- Frame length: ROWS × row length + 1 (DONE). `busy` falls the edge after `frame_done`.
- `row_enable` is never high in the cycle `row_select` changes.
- `row_rst` and `read_req` are never high together.
- `read_req` drops on the edge that samples the ack.
- Asynchronous reset mid-frame clears everything immediately. Operation resumes only via a new `start` after `reset_n` deasserts.

## Test plan
- ROWS=4, RST=2, SETTLE=2, exposure=3, `read_ack` tied 1, start at edge 0 → each row 9 cycles (1 SETUP, 2 RST, 3 INT, 2 SETTLE, 1 READ); `row_select` 0,1,2,3; `frame_done` pulses in cycle 37; `busy` low from cycle 38.
- Same setup, `read_ack` delayed 5 cycles per row → `read_req` held 5 cycles per row and row_select unchanged; frame extends by 16 cycles.
- exposure=0 → INTEGRATE skipped; row length 6; `row_enable` stays high from ROW_RST through READ.
- `abort` in row 2 INTEGRATE → next cycle IDLE, all outputs 0, no `frame_done`. A `start` two cycles later runs a full frame from row 0.
- `start` pulsed during busy and exposure changed mid-frame → ignored; frame timing unchanged. `start`+`abort` together in IDLE → stays IDLE.
- `reset_n` low mid-READ → outputs 0 immediately. Assertions throughout: `row_enable` never high when `row_select` changes; `row_rst` and `read_req` never both high.
